// File: rtl/scrypt_pkg.sv
// Shared definitions for the scratch line responder.
// Holds the default geometry (line address width, line width, beat width,
// beats per line) and the state encoding used by the responder's controller.
package scrypt_pkg;

    localparam int SCR_ADDR_W = 17;
    localparam int SCR_LINE_W = 1024;
    localparam int SCR_BEAT_W = 128;
    localparam int SCR_BEATS  = SCR_LINE_W / SCR_BEAT_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } scr_state_t;

endpackage

// File: rtl/scratch_responder.sv
// scratch_responder: turns whole-line scratch reads/writes into BEATS
// consecutive beat accesses on a simple synchronous memory port.
// Latency: write done BEATS+1 cycles after acceptance, read done BEATS+2
// (2 on a bypass hit). Requests are sampled only while idle; any request
// presented while scratch_busy is high is dropped, there is no stall path.
// Ports: clk/rst (async, active-high); scratch_* = line-side request,
// data, done pulse and busy; mem_* = beat-side cs/we/addr/wdata/rdata,
// with mem_rdata returned one cycle after each read beat.
// Build option: SCRATCH_WB_BYPASS_EN keeps a copy of the last written line
// and serves reads of that address without touching memory.
module scratch_responder
    import scrypt_pkg::*;
#(
    parameter int ADDR_W = SCR_ADDR_W,
    parameter int LINE_W = SCR_LINE_W,
    parameter int BEAT_W = SCR_BEAT_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       scratch_read,
    input  logic                                       scratch_write,
    input  logic [ADDR_W-1:0]                          scratch_addr,
    input  logic [LINE_W-1:0]                          scratch_in,
    output logic [LINE_W-1:0]                          scratch_out,
    output logic                                       scratch_done,
    output logic                                       scratch_busy,
    output logic                                       mem_cs,
    output logic                                       mem_we,
    output logic [ADDR_W+$clog2(LINE_W/BEAT_W)-1:0]    mem_addr,
    output logic [BEAT_W-1:0]                          mem_wdata,
    input  logic [BEAT_W-1:0]                          mem_rdata
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int BW    = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    scr_state_t          r_state;
    logic [BW-1:0]       r_beat;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_line;     // write data, or read assembly buffer
    logic [LINE_W-1:0]   r_out;
    logic                r_mem_cs;
    logic                r_mem_we;
    logic                r_done;
    logic                r_busy;
    // Read data trails its beat by one cycle: remember which slice it fills.
    logic                r_rd_vld;
    logic [BW-1:0]       r_rd_idx;
    logic [LINE_W-1:0]   w_merged;

`ifdef SCRATCH_WB_BYPASS_EN
    logic                r_byp_vld;
    logic [ADDR_W-1:0]   r_byp_addr;
    logic [LINE_W-1:0]   r_byp_line;
    logic                r_byp_hit;
`endif

    // Assembly buffer with the beat currently on mem_rdata folded in; in
    // DRAIN this is the complete line.
    always_comb begin
        w_merged = r_line;
        if (r_rd_vld) begin
            w_merged[r_rd_idx*BEAT_W +: BEAT_W] = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_addr     <= '0;
            r_line     <= '0;
            r_out      <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
`ifdef SCRATCH_WB_BYPASS_EN
            r_byp_vld  <= 1'b0;
            r_byp_addr <= '0;
            r_byp_line <= '0;
            r_byp_hit  <= 1'b0;
`endif
        end else begin
            r_rd_vld <= r_mem_cs & ~r_mem_we;
            r_rd_idx <= r_beat;
            r_line   <= w_merged;
            case (r_state)
                IDLE: begin
                    // Write wins when both requests are raised together.
                    if (scratch_write) begin
                        r_state  <= WRITE;
                        r_addr   <= scratch_addr;
                        r_line   <= scratch_in;
                        r_beat   <= '0;
                        r_mem_cs <= 1'b1;
                        r_mem_we <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef SCRATCH_WB_BYPASS_EN
                        r_byp_vld  <= 1'b1;
                        r_byp_addr <= scratch_addr;
                        r_byp_line <= scratch_in;
`endif
                    end else if (scratch_read) begin
                        r_addr <= scratch_addr;
                        r_beat <= '0;
                        r_busy <= 1'b1;
`ifdef SCRATCH_WB_BYPASS_EN
                        if (r_byp_vld && (r_byp_addr == scratch_addr)) begin
                            // Line already held locally: skip straight to DRAIN.
                            r_state   <= DRAIN;
                            r_byp_hit <= 1'b1;
                        end else begin
                            r_state   <= READ;
                            r_mem_cs  <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_byp_hit <= 1'b0;
                        end
`else
                        r_state  <= READ;
                        r_mem_cs <= 1'b1;
                        r_mem_we <= 1'b0;
`endif
                    end
                end
                WRITE, READ: begin
                    // Counter wraps naturally; it never carries into r_addr.
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        r_mem_cs <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (r_state == WRITE) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
`ifdef SCRATCH_WB_BYPASS_EN
                    r_out <= r_byp_hit ? r_byp_line : w_merged;
`else
                    r_out <= w_merged;
`endif
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign scratch_out  = r_out;
    assign scratch_done = r_done;
    assign scratch_busy = r_busy;
    assign mem_cs       = r_mem_cs;
    assign mem_we       = r_mem_we;
    assign mem_addr     = {r_addr, r_beat};
    assign mem_wdata    = r_line[r_beat*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_scratch_responder.sv
// Bench for scratch_responder: line-level reference model plus scoreboard.
// The driver pushes expected beats and completions as it issues requests;
// a negedge monitor pops and compares whenever mem_cs or scratch_done is seen.
module tb_scratch_responder;

    localparam int ADDR_W = 17;
    localparam int LINE_W = 1024;
    localparam int BEAT_W = 128;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BW     = 3;
    localparam int MA_W   = ADDR_W + BW;
`ifdef SCRATCH_WB_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              scratch_read, scratch_write;
    logic [ADDR_W-1:0] scratch_addr;
    logic [LINE_W-1:0] scratch_in, scratch_out;
    logic              scratch_done, scratch_busy;
    logic              mem_cs, mem_we;
    logic [MA_W-1:0]   mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    scratch_responder dut (
        .clk(clk), .rst(rst),
        .scratch_read(scratch_read), .scratch_write(scratch_write),
        .scratch_addr(scratch_addr), .scratch_in(scratch_in),
        .scratch_out(scratch_out), .scratch_done(scratch_done),
        .scratch_busy(scratch_busy), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit                is_read;
        logic [LINE_W-1:0] out;
        int                lat;
        int                t_drive;
    } txn_t;

    typedef struct {
        bit                we;
        logic [MA_W-1:0]   addr;
        logic [BEAT_W-1:0] data;
    } beat_t;

    txn_t txq[$];
    beat_t bq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dones_seen = 0;
    int dones_exp = 0;

    // Reference model state: whole lines by line address.
    logic [LINE_W-1:0] ref_lines [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] last_out;
    bit                byp_vld;
    logic [ADDR_W-1:0] byp_addr;

    // Environment memory, beat addressed.
    logic [BEAT_W-1:0] mem [logic [MA_W-1:0]];

    function automatic logic [BEAT_W-1:0] init_beat(input logic [MA_W-1:0] a);
        logic [31:0] h;
        h = 32'h9E37_79B9 * {12'd0, a} + 32'h1234_5677;
        return {h, ~h, h ^ 32'hA5A5_A5A5, {12'd0, a}};
    endfunction

    function automatic logic [LINE_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        if (ref_lines.exists(a)) return ref_lines[a];
        for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = init_beat({a, BW'(k)});
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : init_beat(mem_addr);
        end
    end

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every bus beat and every completion against the queues.
    beat_t mon_b;
    txn_t  mon_t;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_cs) begin
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_beat: got addr %0h we %0b want no beat", mem_addr, mem_we);
                end else begin
                    mon_b = bq.pop_front();
                    chk("beat_we", LINE_W'(mem_we), LINE_W'(mon_b.we));
                    chk("beat_addr", LINE_W'(mem_addr), LINE_W'(mon_b.addr));
                    if (mon_b.we) chk("beat_wdata", LINE_W'(mem_wdata), LINE_W'(mon_b.data));
                end
            end
            if (scratch_done) begin
                dones_seen++;
                if (txq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_done: got done at cycle %0d want none", cyc);
                end else begin
                    mon_t = txq.pop_front();
                    chk("done_latency", LINE_W'(cyc - mon_t.t_drive), LINE_W'(mon_t.lat));
                    chk("scratch_out", scratch_out, mon_t.out);
                    chk("busy_in_done", LINE_W'(scratch_busy), LINE_W'(1));
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d);
        txn_t  t;
        beat_t b;
        @(negedge clk);
        scratch_read  = rd;
        scratch_write = wr;
        scratch_addr  = a;
        scratch_in    = d;
        t.t_drive = cyc;
        if (wr) begin
            ref_lines[a] = d;
            for (int k = 0; k < BEATS; k++) begin
                b.we = 1'b1; b.addr = {a, BW'(k)}; b.data = d[k*BEAT_W +: BEAT_W];
                bq.push_back(b);
            end
            t.is_read = 1'b0; t.lat = BEATS + 1; t.out = last_out;
            byp_vld = 1'b1; byp_addr = a;
        end else if (rd) begin
            t.is_read = 1'b1;
            t.out = ref_read(a);
            last_out = t.out;
            if (BYP_EN && byp_vld && byp_addr == a) begin
                t.lat = 2;
            end else begin
                t.lat = BEATS + 2;
                for (int k = 0; k < BEATS; k++) begin
                    b.we = 1'b0; b.addr = {a, BW'(k)}; b.data = '0;
                    bq.push_back(b);
                end
            end
        end
        if (rd || wr) begin
            txq.push_back(t);
            dones_exp++;
        end
        @(negedge clk);
        scratch_read  = 1'b0;
        scratch_write = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((scratch_busy || txq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d want idle within %0d", scratch_busy, txq.size(), budget);
        end
        chk("beats_left", LINE_W'(bq.size()), LINE_W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] line35;
        logic [ADDR_W-1:0] a;
        int op, n;
        rst = 1'b0; scratch_read = 1'b0; scratch_write = 1'b0;
        scratch_addr = '0; scratch_in = '0; mem_rdata = '0;
        last_out = '0; byp_vld = 1'b0; byp_addr = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out", scratch_out, '0);
        chk("rst_done", LINE_W'(scratch_done), '0);
        chk("rst_busy", LINE_W'(scratch_busy), '0);
        chk("rst_cs", LINE_W'(mem_cs), '0);
        chk("rst_we", LINE_W'(mem_we), '0);
        rst = 1'b0;

        // Line 0x5, beat k = k+1: beats at 0x28..0x2F carrying 1..8.
        for (int k = 0; k < BEATS; k++) line35[k*BEAT_W +: BEAT_W] = BEAT_W'(k + 1);
        issue(1'b0, 1'b1, 17'h00005, line35); wait_idle(40);
        issue(1'b1, 1'b0, 17'h00005, '0);     wait_idle(40);
        // Both requests high: write only, beats 0xFFFF8..0xFFFFF.
        issue(1'b1, 1'b1, 17'h1FFFF, rnd_line()); wait_idle(40);

        // A request arriving on cycle 3 of a write must be dropped.
        issue(1'b0, 1'b1, 17'h00033, rnd_line());
        @(negedge clk);
        scratch_read = 1'b1; scratch_write = 1'b1; scratch_addr = 17'h00044;
        @(negedge clk);
        scratch_read = 1'b0; scratch_write = 1'b0;
        wait_idle(40);

        // Reset on beat 4 of a read: abort with no done, outputs cleared.
        issue(1'b1, 1'b0, 17'h00061, '0);
        n = 0;
        while (!(mem_cs && mem_addr[BW-1:0] == 3'd4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat4_found", LINE_W'(n < 20), LINE_W'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_cs", LINE_W'(mem_cs), '0);
        chk("abort_done", LINE_W'(scratch_done), '0);
        chk("abort_busy", LINE_W'(scratch_busy), '0);
        chk("abort_out", scratch_out, '0);
        txq.delete(); bq.delete(); dones_exp--;
        last_out = '0; byp_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 1'b0, 17'h00061, '0); wait_idle(40);

        // Write then read the same line (bypass hit when enabled), then a neighbour.
        issue(1'b0, 1'b1, 17'h00010, rnd_line()); wait_idle(40);
        issue(1'b1, 1'b0, 17'h00010, '0);         wait_idle(40);
        issue(1'b1, 1'b0, 17'h00011, '0);         wait_idle(40);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            issue(op != 0, op != 1, a, rnd_line());
            wait_idle(40);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("done_count", LINE_W'(dones_seen), LINE_W'(dones_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scratch_responder.md
SCRATCH_RESPONDER -- requirements
Module: scratch_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, line address width.
REQ-002 SHALL have parameter LINE_W, default 1024, scratch line width.
REQ-003 SHALL have parameter BEAT_W, default 128, memory beat width; BEATS = LINE_W/BEAT_W (default 8).
REQ-004 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous and active-high.
REQ-006 SHALL have port scratch_read  in  1  line read request.
REQ-007 SHALL have port scratch_write  in  1  line write request.
REQ-008 SHALL have port scratch_addr  in  ADDR_W  line address.
REQ-009 SHALL have port scratch_in  in  LINE_W  write line data.
REQ-010 SHALL have port scratch_out  out  LINE_W  read line data.
REQ-011 SHALL have port scratch_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port scratch_busy  out  1  transaction in progress.
REQ-013 SHALL have port mem_cs  out  1  memory beat enable.
REQ-014 SHALL have port mem_we  out  1  memory write strobe.
REQ-015 SHALL have port mem_addr  out  ADDR_W+log2(BEATS)  beat address = {line addr, beat index}.
REQ-016 SHALL have port mem_wdata  out  BEAT_W  write beat.
REQ-017 SHALL have port mem_rdata  in  BEAT_W  read beat, valid exactly one cycle after a mem_cs read beat.

Function
REQ-018 SHALL use FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-019 SHALL sample requests only in IDLE; requests while scratch_busy=1 SHALL be ignored.
REQ-020 SHALL treat scratch_read and scratch_write both high as a write; the read is dropped.
REQ-021 SHALL latch scratch_addr, and scratch_in for writes, on the accepting edge.
REQ-022 WRITE: SHALL drive BEATS consecutive cycles with mem_cs=1 and mem_we=1; beat k carries line bits [BEAT_W*k +: BEAT_W] at beat index k, k = 0..BEATS-1 ascending.
REQ-023 READ: SHALL drive BEATS consecutive cycles with mem_cs=1 and mem_we=0; DRAIN SHALL capture the final mem_rdata one cycle after the last beat; beat k fills scratch_out bits [BEAT_W*k +: BEAT_W].
REQ-024 SHALL pulse scratch_done for exactly one cycle, in DONE, then return to IDLE; write done SHALL occur BEATS+1 cycles after acceptance and read done BEATS+2 cycles after acceptance (9 and 10 by default).
REQ-025 SHALL update scratch_out only when a read completes and hold it otherwise, including across writes.
REQ-026 SHALL hold scratch_busy=1 from the cycle after acceptance through DONE inclusive.
REQ-027 SHALL hold mem_cs=0 and mem_we=0 in IDLE and DONE; mem_addr and mem_wdata are don't-care when mem_cs=0.
REQ-028 SHALL wrap the beat counter from BEATS-1 to 0 with no carry into the line address.

Reset
REQ-029 SHALL, while rst=1, force FSM to IDLE, all outputs to 0, beat counter to 0, and bypass state invalid.
REQ-030 SHALL abort any transaction immediately on reset, with no scratch_done; a partially written line is left undefined in memory.

Configuration
REQ-031 With SCRATCH_WB_BYPASS_EN defined, SHALL keep a copy of the last written line and its address; a read hitting that address SHALL complete with no mem_cs activity, with scratch_done two cycles after acceptance.
REQ-032 Without SCRATCH_WB_BYPASS_EN, every read SHALL access memory per REQ-023, and no line copy register SHALL exist.

Structure
REQ-033 SHALL take ADDR_W, LINE_W, BEAT_W, BEATS defaults and the state enum typedef from shared package scrypt_pkg.
REQ-034 SHALL be a single module with no sub-modules; beat counter and FSM are inline.

Verification
REQ-035 Write line addr 0x00005 with data = beat k filled with 128-bit value k+1 -> mem_addr 0x28..0x2F with wdata 1..8 in order, scratch_done 9 cycles after acceptance.
REQ-036 Read addr 0x00005, with a memory model returning the stored data -> scratch_out equals the REQ-035 line, scratch_done 10 cycles after acceptance, no mem_we.
REQ-037 scratch_read and scratch_write both high, addr 0x1FFFF -> write-only beats at mem_addr 0xFFFF8..0xFFFFF; no read is performed.
REQ-038 New request on cycle 3 of a write -> ignored; exactly one scratch_done is produced.
REQ-039 rst asserted on beat 4 of a read -> mem_cs=0 asynchronously, no scratch_done, scratch_out=0; next read completes normally.
REQ-040 SCRATCH_WB_BYPASS_EN defined: write 0x00010, then read 0x00010 -> zero read beats, done 2 cycles after acceptance; read 0x00011 -> normal 8-beat read.
